// File: rtl/demosaic_pkg.sv
// Shared constants and FSM encoding for the Bayer demosaic front end and kernel wrappers.
package demosaic_pkg;

    localparam int unsigned DW          = 8;
    localparam int unsigned CW          = 12;
    localparam int unsigned MAX_W       = 2048;
    localparam int unsigned FLUSH_LINES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSof,
        StActive,
        StFlush,
        StDone
    } state_e;

endpackage

// File: rtl/dmsc_axis_reg.sv
// Single-stage AXI-stream register slice; in_ready is high whenever the slot is empty or draining.
module dmsc_axis_reg
    import demosaic_pkg::*;
#(
    parameter int unsigned W = DW + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/demosaic_stream_ctrl.sv
// Frame sequencer ahead of the 3x3 demosaic kernel: SOF lock, regenerated framing, zero-line flush.
// Optional input-tlast checking is built when DMSC_LINE_CHECK_EN is defined.
module demosaic_stream_ctrl
    import demosaic_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          cfg_stop,
    input  logic [CW-1:0] cfg_width,
    input  logic [CW-1:0] cfg_height,
    input  logic          cfg_continuous,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tuser,
    input  logic          s_axis_tlast,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          s_axis_tready,
    output logic          m_axis_tvalid,
    output logic          m_axis_tuser,
    output logic          m_axis_tlast,
    output logic [DW-1:0] m_axis_tdata,
    input  logic          m_axis_tready,
    output logic          busy,
    output logic          frame_done,
    output logic          err_sof,
`ifdef DMSC_LINE_CHECK_EN
    output logic          err_line,
    output logic [15:0]   err_line_cnt,
`endif
    output logic [15:0]   drop_cnt
);

    state_e        state_q, state_d;
    logic [CW-1:0] width_q, height_q;
    logic          cont_q;
    logic          stop_pend_q, stop_pend_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic          err_sof_q, err_sof_d;
    logic [15:0]   drop_q, drop_d;

    logic          reg_free, push, pix_adv, s_ready;
    logic [DW+1:0] push_data, m_word;
    logic [CW-1:0] eff_col, eff_row;
    logic          gen_last, last_row;

    // A tuser pixel always restarts framing at the origin.
    assign eff_col  = s_axis_tuser ? '0 : col_q;
    assign eff_row  = s_axis_tuser ? '0 : row_q;
    assign gen_last = (eff_col == width_q - CW'(1));
    assign last_row = (eff_row == height_q - CW'(1));

`ifdef DMSC_LINE_CHECK_EN
    logic        line_err_q, line_err_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic        line_bad_q, line_bad_d;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q | cfg_stop;
        col_d       = col_q;
        row_d       = row_q;
        err_sof_d   = err_sof_q;
        drop_d      = drop_q;
        s_ready     = 1'b0;
        push        = 1'b0;
        pix_adv     = 1'b0;
        push_data   = '0;
`ifdef DMSC_LINE_CHECK_EN
        line_err_d  = line_err_q;
        line_cnt_d  = line_cnt_q;
        line_bad_d  = line_bad_q;
`endif
        case (state_q)
            StIdle: begin
                stop_pend_d = 1'b0;
                if (cfg_start) begin
                    state_d   = StWaitSof;
                    err_sof_d = 1'b0;
                    drop_d    = '0;
                    col_d     = '0;
                    row_d     = '0;
`ifdef DMSC_LINE_CHECK_EN
                    line_err_d = 1'b0;
                    line_cnt_d = '0;
                    line_bad_d = 1'b0;
`endif
                end
            end
            StWaitSof: begin
                // Non-SOF pixels are always drained; the SOF pixel waits for a free output slot.
                s_ready = !(s_axis_tvalid & s_axis_tuser) | reg_free;
                if (s_axis_tvalid) begin
                    if (!s_axis_tuser) begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end else if (reg_free) begin
                        state_d = StActive;
                        pix_adv = 1'b1;
`ifdef DMSC_LINE_CHECK_EN
                        line_bad_d = 1'b0;
`endif
                    end
                end
            end
            StActive: begin
                s_ready = reg_free;
                if (s_axis_tvalid && reg_free) begin
                    pix_adv = 1'b1;
                    if (s_axis_tuser && (row_q != '0 || col_q != '0)) begin
                        err_sof_d = 1'b1;
                    end
`ifdef DMSC_LINE_CHECK_EN
                    // One count per line: an early tlast suppresses the later missing-tlast hit.
                    if ((s_axis_tlast && !gen_last) || (gen_last && !s_axis_tlast
                                                        && !(line_bad_q && !s_axis_tuser))) begin
                        line_err_d = 1'b1;
                        if (line_cnt_q != 16'hFFFF) begin
                            line_cnt_d = line_cnt_q + 16'd1;
                        end
                    end
                    line_bad_d = s_axis_tlast && !gen_last;
                    if (!gen_last && !s_axis_tlast && !s_axis_tuser) begin
                        line_bad_d = line_bad_q;
                    end
`endif
                end
            end
            StFlush: begin
                push      = 1'b1;
                push_data = {1'b0, (col_q == width_q - CW'(1)), {DW{1'b0}}};
                if (reg_free) begin
                    if (col_q == width_q - CW'(1)) begin
                        col_d = '0;
                        if (row_q == CW'(FLUSH_LINES - 1)) begin
                            row_d   = '0;
                            state_d = StDone;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDone: begin
                if (cont_q && !(stop_pend_q || cfg_stop)) begin
                    state_d = StWaitSof;
                end else begin
                    state_d     = StIdle;
                    stop_pend_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (pix_adv) begin
            push      = 1'b1;
            push_data = {(eff_row == '0 && eff_col == '0), gen_last, s_axis_tdata};
            if (gen_last) begin
                col_d = '0;
                if (last_row) begin
                    row_d   = '0;
                    state_d = StFlush;
                end else begin
                    row_d = eff_row + CW'(1);
                end
            end else begin
                col_d = eff_col + CW'(1);
                row_d = eff_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            width_q     <= '0;
            height_q    <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            err_sof_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            col_q       <= col_d;
            row_q       <= row_d;
            err_sof_q   <= err_sof_d;
            drop_q      <= drop_d;
            if (state_q == StIdle && cfg_start) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
                cont_q   <= cfg_continuous;
            end
        end
    end

`ifdef DMSC_LINE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            line_err_q <= 1'b0;
            line_cnt_q <= '0;
            line_bad_q <= 1'b0;
        end else begin
            line_err_q <= line_err_d;
            line_cnt_q <= line_cnt_d;
            line_bad_q <= line_bad_d;
        end
    end

    assign err_line     = line_err_q;
    assign err_line_cnt = line_cnt_q;
`endif

    dmsc_axis_reg #(
        .W(DW + 2)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (push),
        .in_data  (push_data),
        .in_ready (reg_free),
        .out_valid(m_axis_tvalid),
        .out_data (m_word),
        .out_ready(m_axis_tready)
    );

    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_word;

    assign s_axis_tready = s_ready;
    assign busy          = (state_q != StIdle);
    assign frame_done    = (state_q == StDone);
    assign err_sof       = err_sof_q;
    assign drop_cnt      = drop_q;

endmodule
